// File: rtl/logic_unit_serial.sv
// ---------------------------------------------------------------------------
// logic_unit_serial
//
// Slice-serial bitwise logic unit. An operand pair and an opcode are accepted
// over a valid/ready handshake. The result is built SLICE bits per cycle,
// starting with the least significant slice, and is returned over a second
// valid/ready handshake. It is a low-area alternative to a flat combinational
// logic unit.
//
// Parameters:
//   WIDTH  operand/result width. Must be a multiple of SLICE.
//   SLICE  number of result bits computed per cycle.
//
// Ports:
//   clock      in   rising-edge clock
//   reset_n    in   synchronous, active-low reset
//   in_valid   in   operand request valid
//   in_ready   out  unit can accept a request (IDLE only)
//   operandA   in   first operand (captured on accept)
//   operandB   in   second operand (captured on accept)
//   opcode     in   00 AND, 01 OR, 10 XOR, 11 NOR
//   out_valid  out  result valid (DONE)
//   out_ready  in   consumer accepts the result
//   result     out  result register
//   busy       out  high whenever the FSM is not in IDLE
//   zero       out  result == 0. This port exists only when the macro
//                   LOGIC_UNIT_SERIAL_ZERO_EN is defined.
//
// Configuration macro: LOGIC_UNIT_SERIAL_ZERO_EN adds the registered zero flag.
// ---------------------------------------------------------------------------
module logic_unit_serial #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic [1:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
`ifdef LOGIC_UNIT_SERIAL_ZERO_EN
    ,
    output logic             zero
`endif
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [1:0]         op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [SLICE-1:0]   slice_res;
`ifdef LOGIC_UNIT_SERIAL_ZERO_EN
    logic               zero_q, zero_d;
`endif

    function automatic logic [SLICE-1:0] slice_op(
        input logic [SLICE-1:0] a,
        input logic [SLICE-1:0] b,
        input logic [1:0]       op
    );
        logic [SLICE-1:0] r;
        case (op)
            2'b00:   r = a & b;
            2'b01:   r = a | b;
            2'b10:   r = a ^ b;
            default: r = ~(a | b);
        endcase
        return r;
    endfunction

    // The captured operands are shifted right by one slice per RUN cycle.
    // The logic op therefore always reads the low slice, and no wide read
    // multiplexer is needed.
    assign slice_res = slice_op(a_q[SLICE-1:0], b_q[SLICE-1:0], op_q);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        result_d = result_q;
`ifdef LOGIC_UNIT_SERIAL_ZERO_EN
        zero_d   = zero_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = operandA;
                    b_d      = operandB;
                    op_d     = opcode;
                    result_d = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                result_d[int'(cnt_q) * SLICE +: SLICE] = slice_res;
                a_d = a_q >> SLICE;
                b_d = b_q >> SLICE;
`ifdef LOGIC_UNIT_SERIAL_ZERO_EN
                // Unwritten slices are still zero from the accept-time
                // clear, so comparing the whole register covers exactly
                // the slices written so far.
                zero_d = (result_d == '0);
`endif
                // The counter holds at the last slice instead of wrapping.
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
`ifdef LOGIC_UNIT_SERIAL_ZERO_EN
            zero_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
`ifdef LOGIC_UNIT_SERIAL_ZERO_EN
            zero_q   <= zero_d;
`endif
        end
    end

    // These outputs are decoded only from the state register, so no input
    // reaches an output combinationally.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign result    = result_q;
`ifdef LOGIC_UNIT_SERIAL_ZERO_EN
    assign zero      = zero_q;
`endif

endmodule

// File: tb/tb_logic_unit_serial.sv
// ---------------------------------------------------------------------------
// tb_logic_unit_serial
//
// Directed-vector bench for logic_unit_serial with a scoreboard.
//
// Issuing a request pushes its hand-computed expected result onto a queue.
// A monitor process pops the queue and compares at every output handshake.
// The stimulus process also makes direct checks on reset state, latency,
// backpressure and handshake timing.
// ---------------------------------------------------------------------------
module tb_logic_unit_serial;

    localparam int WIDTH  = 32;
    localparam int SLICE  = 4;
    localparam int NSLICE = WIDTH / SLICE;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] operandA = '0;
    logic [WIDTH-1:0] operandB = '0;
    logic [1:0]       opcode = 2'b00;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] result;
    logic             busy;
`ifdef LOGIC_UNIT_SERIAL_ZERO_EN
    logic             zero;
`endif

    logic_unit_serial #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operandA  (operandA),
        .operandB  (operandB),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
`ifdef LOGIC_UNIT_SERIAL_ZERO_EN
        ,
        .zero      (zero)
`endif
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             zero;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   txn   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: a handshake is seen at the falling edge before the rising edge
    // that completes it.
    always @(negedge clock) begin
        if (reset_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got 0x%08h, expected no output", result);
            end else begin
                mon_e = sb.pop_front();
                txn++;
                $display("txn %0d: result=0x%08h expected=0x%08h", txn, result, mon_e.res);
                chk("result", result, mon_e.res);
`ifdef LOGIC_UNIT_SERIAL_ZERO_EN
                chk("zero", 32'(zero), 32'(mon_e.zero));
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                        input logic [31:0] exp_res, input bit push);
        exp_t e;
        int   n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("accept_ready", 32'(in_ready), 32'd1);
        operandA = a;
        operandB = b;
        opcode   = op;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        if (push) begin
            e.res  = exp_res;
            e.zero = (exp_res == 32'h0);
            sb.push_back(e);
        end
    endtask

    // Counts the cycles from the accept edge until out_valid is seen. The
    // wait is bounded; on timeout the count exceeds NSLICE.
    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!out_valid && lat < 40);
    endtask

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] op, input logic [31:0] exp_res);
        int lat;
        send(a, b, op, exp_res, 1'b1);
        wait_valid(lat);
        chk({name, "_latency"}, 32'(lat), 32'(NSLICE));
        tick();
        chk({name, "_ready_after"}, 32'(in_ready), 32'd1);
        chk({name, "_valid_drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int lat;
        int n;

        // Reset state
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", result, 32'h0);
`ifdef LOGIC_UNIT_SERIAL_ZERO_EN
        chk("rst_zero", 32'(zero), 32'd0);
`endif

        // AND with latency check
        run_op("and", 32'h0000FFFF, 32'hCA8CF1C5, 2'b00, 32'h0000F1C5);

        // Opcode sweep
        run_op("sw_and", 32'hF0F0F0F0, 32'hFF00FF00, 2'b00, 32'hF000F000);
        run_op("sw_or",  32'hF0F0F0F0, 32'hFF00FF00, 2'b01, 32'hFFF0FFF0);
        run_op("sw_xor", 32'hF0F0F0F0, 32'hFF00FF00, 2'b10, 32'h0FF00FF0);
        run_op("sw_nor", 32'hF0F0F0F0, 32'hFF00FF00, 2'b11, 32'h000F000F);

        // Backpressure: hold in DONE and offer requests that must be ignored
        out_ready = 1'b0;
        send(32'h00FF00FF, 32'h0F0F0F0F, 2'b10, 32'h0FF00FF0, 1'b1);
        wait_valid(lat);
        chk("bp_latency", 32'(lat), 32'(NSLICE));
        for (int i = 0; i < 5; i++) begin
            operandA = 32'hFFFFFFFF;
            operandB = 32'h12345678;
            opcode   = 2'b01;
            in_valid = (i % 2 == 0);
            tick();
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_result", result, 32'h0FF00FF0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        chk("bp_release_busy", 32'(busy), 32'd0);
        repeat (NSLICE + 2) tick();
        chk("bp_not_taken", 32'(busy), 32'd0);

        // Reset during RUN, with slice 4 in progress
        send(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 32'h0, 1'b0);
        repeat (4) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_result", result, 32'h0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        run_op("post_rst_or", 32'h12345678, 32'h0F0F0F0F, 2'b01, 32'h1F3F5F7F);

        // Operand and opcode changes after capture must not matter
        send(32'h00000000, 32'hFFFFFFFF, 2'b00, 32'h00000000, 1'b1);
        operandA = 32'hFFFFFFFF;
        opcode   = 2'b01;
        wait_valid(lat);
        chk("stab_latency", 32'(lat), 32'(NSLICE));
        tick();

        // Zero-result and nonzero-result cases
        run_op("z_and", 32'hAAAAAAAA, 32'h55555555, 2'b00, 32'h00000000);
        run_op("z_or",  32'hAAAAAAAA, 32'h55555555, 2'b01, 32'hFFFFFFFF);

        // Drain the scoreboard
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        chk("txn_count", 32'(txn), 32'd10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
